// File: rtl/pipe_stage_chain_pkg.sv
// Shared CPU pipeline definitions: default payload/depth constants, the stage
// index type and the per-slot control bundle.
package pipe_stage_chain_pkg;

    localparam int PSC_WIDTH = 32;
    localparam int PSC_DEPTH = 4;
    localparam int PSC_CNT_W = 16;

    typedef logic [$clog2(PSC_DEPTH)-1:0] stage_idx_t;

    typedef struct packed {
        logic flush;
        logic accept;
        logic load;
    } slot_ctrl_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, hazard-control and stage-tap bundle of the pipeline backbone.
interface pipe_stage_chain_if
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH = PSC_WIDTH,
    parameter int DEPTH = PSC_DEPTH,
    parameter int CNT_W = PSC_CNT_W
);

    logic                       in_valid_i;
    logic [WIDTH-1:0]           in_data_i;
    logic                       in_ready_o;
    logic                       out_valid_o;
    logic [WIDTH-1:0]           out_data_o;
    logic                       out_ready_i;
    logic [DEPTH-1:0]           stall_i;
    logic [DEPTH-1:0]           flush_i;
    logic [DEPTH-1:0]           stage_valid_o;
    logic [DEPTH*WIDTH-1:0]     stage_data_o;
    logic [$clog2(DEPTH+1)-1:0] occupancy_o;
    logic [CNT_W-1:0]           squash_cnt_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
        output in_ready_o, out_valid_o, out_data_o, stage_valid_o,
               stage_data_o, occupancy_o, squash_cnt_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
        input  in_ready_o, out_valid_o, out_data_o, stage_valid_o,
               stage_data_o, occupancy_o, squash_cnt_o
    );

endinterface

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: valid bit plus payload register with flush, load and hold.
module pipe_stage_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH = PSC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  slot_ctrl_t       ctrl_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             valid_d_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next state: flush empties the slot, an accepting slot takes whatever moves in.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ctrl_i.flush) begin
            valid_d = 1'b0;
        end else if (ctrl_i.accept) begin
            valid_d = ctrl_i.load;
        end else begin
            valid_d = valid_q;
        end
        if (ctrl_i.load && !ctrl_i.flush) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;
    assign data_o    = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Pipeline backbone: DEPTH slots joined by a combinational accept/move chain,
// with per-stage stall/flush, occupancy and a saturating squash counter.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH = PSC_WIDTH,
    parameter int DEPTH = PSC_DEPTH,
    parameter int CNT_W = PSC_CNT_W
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_stage_chain_if.slave chain_if
);

    localparam int              OCC_W   = $clog2(DEPTH + 1);
    localparam int              SUM_W   = CNT_W + OCC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // move_s[k] is the transfer into stage k, so move_s[0] is the producer handoff.
    logic [DEPTH:0]   accept_s;
    logic [DEPTH:0]   move_s;
    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_q;
    logic [CNT_W-1:0] squash_d;
    logic [CNT_W-1:0] squash_q;
    logic [SUM_W-1:0] squash_inc_s;
    logic [SUM_W-1:0] squash_sum_s;

    // Accept ripples back from the consumer; a flushed or stalled full stage blocks it.
    always_comb begin
        logic [DEPTH:0] acc;
        logic [DEPTH:0] mv;
        acc        = '0;
        mv         = '0;
        acc[DEPTH] = chain_if.out_ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            mv[k+1] = valid_s[k] & ~chain_if.stall_i[k] & ~chain_if.flush_i[k] & acc[k+1];
            acc[k]  = ~valid_s[k] | mv[k+1];
        end
        mv[0]    = chain_if.in_valid_i & acc[0];
        accept_s = acc;
        move_s   = mv;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        slot_ctrl_t       ctrl_s;
        logic [WIDTH-1:0] din_s;

        assign ctrl_s = '{flush: chain_if.flush_i[k], accept: accept_s[k], load: move_s[k]};

        if (k == 0) begin : g_head
            assign din_s = chain_if.in_data_i;
        end else begin : g_body
            assign din_s = data_s[k-1];
        end

        pipe_stage_slot #(.WIDTH(WIDTH)) u_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .ctrl_i    (ctrl_s),
            .data_i    (din_s),
            .valid_o   (valid_s[k]),
            .valid_d_o (valid_d[k]),
            .data_o    (data_s[k])
        );

        assign chain_if.stage_data_o[k*WIDTH +: WIDTH] = data_s[k];
    end

    // Occupancy follows next-state valids; squash counts flushed residents and flushed arrivals.
    always_comb begin
        occ_d        = '0;
        squash_inc_s = '0;
        squash_sum_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d        = occ_d + OCC_W'(valid_d[k]);
            squash_inc_s = squash_inc_s
                         + SUM_W'(chain_if.flush_i[k] & valid_s[k])
                         + SUM_W'(chain_if.flush_i[k] & move_s[k]);
        end
        squash_sum_s = SUM_W'(squash_q) + squash_inc_s;
        if (squash_sum_s > SUM_W'(CNT_MAX)) begin
            squash_d = CNT_MAX;
        end else begin
            squash_d = squash_sum_s[CNT_W-1:0];
        end
    end

    // Status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q    <= '0;
            squash_q <= '0;
        end else begin
            occ_q    <= occ_d;
            squash_q <= squash_d;
        end
    end

    assign chain_if.in_ready_o    = accept_s[0];
    assign chain_if.out_valid_o   = valid_s[DEPTH-1] & ~chain_if.stall_i[DEPTH-1]
                                  & ~chain_if.flush_i[DEPTH-1];
    assign chain_if.out_data_o    = data_s[DEPTH-1];
    assign chain_if.stage_valid_o = valid_s;
    assign chain_if.occupancy_o   = occ_q;
    assign chain_if.squash_cnt_o  = squash_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: scoreboard of accepted items against the
// output stream, plus point checks on stall, flush, squash and reset behaviour.
module tb_pipe_stage_chain;
    import pipe_stage_chain_pkg::*;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic [D-1:0] stall;
    logic [D-1:0] flush;

    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_sq = 0;
    logic [W-1:0] sbq[$];

    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) bus ();
    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D), .CNT_W(2))  sbus ();

    assign bus.in_valid_i   = in_valid;
    assign bus.in_data_i    = in_data;
    assign bus.out_ready_i  = out_ready;
    assign bus.stall_i      = stall;
    assign bus.flush_i      = flush;
    assign sbus.in_valid_i  = in_valid;
    assign sbus.in_data_i   = in_data;
    assign sbus.out_ready_i = out_ready;
    assign sbus.stall_i     = stall;
    assign sbus.flush_i     = flush;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .chain_if (bus)
    );

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) u_sat (
        .clk_i    (clk),
        .rst_i    (rst),
        .chain_if (sbus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Transfers happen at the coming edge: pop on output, push on accepted input.
    task automatic mon();
        logic [W-1:0] e;
        if (bus.out_valid_o && out_ready) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_data", bus.out_data_o, e);
            end else begin
                chk("out_valid_unexpected", bus.out_valid_o, 1'b0);
            end
        end
        if (in_valid && bus.in_ready_o && !flush[0]) begin
            sbq.push_back(in_data);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = '0;
        flush     = '0;
        for (int i = 0; i < 12; i++) step();
        chk("drain_empty", sbq.size(), 0);
        chk("drain_occ", bus.occupancy_o, 0);
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        stall     = '0;
        flush     = '0;
        #1;
        chk("rst_stage_valid", bus.stage_valid_o, 4'b0000);
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_in_ready", bus.in_ready_o, 1'b1);
        chk("rst_occ", bus.occupancy_o, 0);
        chk("rst_squash", bus.squash_cnt_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming 0x11..0x18: output valid from the fourth cycle, no gaps.
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            in_data  = 32'h11 + 32'(i);
            half();
            chk("stream_out_valid", bus.out_valid_o, (i >= 4 && i < 12) ? 1'b1 : 1'b0);
            chk("stream_occ", bus.occupancy_o, (i < 4) ? i : ((i <= 8) ? 4 : 12 - i));
            fin();
        end
        drain();

        // Backpressure: full chain holds while the consumer is not ready.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(i);
            step();
        end
        in_data = 32'hA4;
        for (int i = 0; i < 5; i++) begin
            half();
            chk("bp_in_ready", bus.in_ready_o, 1'b0);
            chk("bp_stage_data", bus.stage_data_o,
                128'h000000A0_000000A1_000000A2_000000A3);
            chk("bp_occ", bus.occupancy_o, 4);
            fin();
        end
        drain();

        // Bubble: stage 1 stalled for two cycles while the chain is full.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(i);
            step();
        end
        stall   = 4'b0010;
        in_data = 32'hC4;
        half();
        chk("bub_in_ready0", bus.in_ready_o, 1'b0);
        chk("bub_valid0", bus.stage_valid_o, 4'b1111);
        fin();
        half();
        chk("bub_valid1", bus.stage_valid_o, 4'b1011);
        chk("bub_stage1_hold", bus.stage_data_o[1*W +: W], 32'hC2);
        chk("bub_in_ready1", bus.in_ready_o, 1'b0);
        fin();
        stall = '0;
        half();
        chk("bub_valid2", bus.stage_valid_o, 4'b0011);
        chk("bub_in_ready2", bus.in_ready_o, 1'b1);
        fin();
        for (int i = 5; i < 8; i++) begin
            in_data = 32'hC0 + 32'(i);
            step();
        end
        drain();

        // Branch flush of the two youngest stages while 0xB4 is offered.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB0 + 32'(i);
            step();
        end
        in_data = 32'hB4;
        flush   = 4'b0011;
        half();
        chk("br_in_ready", bus.in_ready_o, 1'b0);
        chk("br_out_valid", bus.out_valid_o, 1'b1);
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        exp_sq += 2;
        fin();
        flush    = '0;
        in_valid = 1'b0;
        half();
        chk("br_valid", bus.stage_valid_o, 4'b1000);
        chk("br_squash", bus.squash_cnt_o, exp_sq);
        chk("br_squash_sat", sbus.squash_cnt_o, sat3(exp_sq));
        fin();
        drain();

        // Flush of stage 0 destroys the item entering it.
        in_valid = 1'b1;
        in_data  = 32'hE0;
        flush    = 4'b0001;
        half();
        chk("ent_in_ready", bus.in_ready_o, 1'b1);
        exp_sq += 1;
        fin();
        flush    = '0;
        in_valid = 1'b0;
        half();
        chk("ent_valid", bus.stage_valid_o, 4'b0000);
        chk("ent_squash", bus.squash_cnt_o, exp_sq);
        chk("ent_squash_sat", sbus.squash_cnt_o, sat3(exp_sq));
        fin();

        // Flush beats stall on the last stage; no transfer despite out_ready.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD0 + 32'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = 4'b1000;
        flush     = 4'b1000;
        half();
        chk("fs_out_valid", bus.out_valid_o, 1'b0);
        chk("fs_in_ready", bus.in_ready_o, 1'b0);
        void'(sbq.pop_front());
        exp_sq += 1;
        fin();
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
        half();
        chk("fs_valid", bus.stage_valid_o, 4'b0111);
        chk("fs_squash", bus.squash_cnt_o, exp_sq);
        chk("fs_squash_sat", sbus.squash_cnt_o, sat3(exp_sq));
        fin();

        // Flush everything: the 2-bit counter must stay saturated, never wrap.
        flush = 4'b1111;
        half();
        chk("fa_out_valid", bus.out_valid_o, 1'b0);
        sbq.delete();
        exp_sq += 3;
        fin();
        flush = '0;
        half();
        chk("fa_valid", bus.stage_valid_o, 4'b0000);
        chk("fa_squash", bus.squash_cnt_o, exp_sq);
        chk("fa_squash_sat", sbus.squash_cnt_o, sat3(exp_sq));
        fin();

        // Asynchronous reset between edges with items in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hF0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stage_valid", bus.stage_valid_o, 4'b0000);
        chk("ar_out_valid", bus.out_valid_o, 1'b0);
        chk("ar_in_ready", bus.in_ready_o, 1'b1);
        chk("ar_squash", bus.squash_cnt_o, 0);
        chk("ar_squash_sat", sbus.squash_cnt_o, 0);
        chk("ar_occ", bus.occupancy_o, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h60 + 32'(i);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
